trigger_scaler_counter: RTL and testbench
=========================================

// Module: trigger_scaler_counter
// PURPOSE
//  Receive end of the trigger scaler path: counts the per-channel scaler pulses (4 TDA + 4 reserved)
//  over a fixed gate period and latches each period's counts into holding registers.
//  A simple req/ack register read port lets the control interface read them.
//  Sits in the slow clock domain, fed directly by the trigger-scaler map outputs.
// PARAMETERS
//  NCH         8        number of scaler channels (bit i of scal_i = channel i; 0-3 TDA, 4-7 rsvd)
//  CNT_WIDTH   16       width of each counter/holding register
//  PERIOD      1000000  gate length in ce_i-qualified cycles (>=2)
//  ADDR_WIDTH  3        read address width, $clog2(NCH)
// PORTS
//  clk_i       in   1            slow clock; all logic in this domain
//  rst_n_i     in   1            asynchronous, active-low reset
//  ce_i        in   1            slow clock enable; qualifies pulses and the period counter
//  scal_i      in   NCH          scaler pulses, one-cycle, sampled only when ce_i=1
//  pps_i       in   1            external gate pulse (used only with TRIG_SCALER_PPS_GATE_EN)
//  rd_req_i    in   1            read request, single-cycle strobe
//  rd_addr_i   in   ADDR_WIDTH   channel to read
//  rd_ack_o    out  1            read acknowledge, one cycle
//  rd_data_o   out  CNT_WIDTH    holding-register value for rd_addr_i
//  update_o    out  1            one-cycle pulse: new period's counts latched
// BEHAVIOUR
//  - Reset: all counters, holding regs, period counter = 0; rd_ack_o=0, rd_data_o=0, update_o=0.
//  - Counting: on clk_i edge with ce_i=1 and scal_i[i]=1, cnt[i] increments by 1.
//    cnt[i] saturates at 2**CNT_WIDTH-1 (no wrap).
//  - Gate: period counter counts ce_i cycles 0..PERIOD-1. The terminal event (tc) is
//    ce_i=1 and period count = PERIOD-1. On tc:
//    - hold[i] <= cnt[i] plus this cycle's pulse, saturated.
//    - cnt[i] <= 0, period counter <= 0.
//    - update_o=1 in the next cycle (registered, one cycle wide).
//  - Pulse on tc cycle: counted into the CLOSING period (loaded into hold); new period starts at 0.
//  - All NCH holding registers update in the same edge, so a snapshot is never partially updated.
//  - Read: rd_req_i=1 at edge N -> at edge N+1, rd_ack_o=1 and rd_data_o=hold[rd_addr_i]
//    (value sampled at edge N). rd_data_o holds its value until the next accepted read.
//    - Read coincident with tc returns the pre-update hold value.
//    - Back-to-back requests are legal: one ack per request, no stalls.
//  - ce_i=0: no counting, no period advance; reads still serviced.
//  - rst_n_i asserted mid-period: counts discarded; the period restarts from 0 after release.
// CONFIGURATION
//  TRIG_SCALER_PPS_GATE_EN defined:
//    - tc = rising edge of pps_i (pps_i registered, edge-detected; ce_i not required).
//    - PERIOD counter not instantiated.
//    - Latch/clear/update_o rules identical to the internal-gate case.
//  Not defined: internal PERIOD gate as above; pps_i ignored.
// STRUCTURE
//  - Shared package trigger_scaler_pkg:
//    - NUM_TDA_CH=4, NUM_RSVD_CH=4.
//    - Default CNT_WIDTH and PERIOD.
//    - Channel index constants (TDA_BASE=0, RSVD_BASE=4).
//  - One sub-module trigger_scaler_chan_cnt, generated per channel:
//    - saturating counter plus holding register.
//    - inputs: clk, rst_n, inc, tc; output: hold.
//  - Top level holds the gate logic, read mux and update_o.
// TESTING
//  1 Reset: rst_n_i=0 mid-run -> all outputs 0; counts restart at 0 after release.
//  2 PERIOD=10, ce_i=1, 3 pulses on ch0, 7 on ch5 -> update_o pulse; reads give hold0=3, hold5=7, others 0.
//  3 Saturation: CNT_WIDTH=4, 20 pulses in one period -> hold=15, no wrap; next empty period reads 0.
//  4 Pulse on the tc cycle -> counted in the closing period (hold += 1); next period starts at 0.
//  5 Read on the tc cycle -> returns the old hold value; read one cycle later returns the new value.
//  6 TRIG_SCALER_PPS_GATE_EN: pps_i edges 50 cycles apart, 4 pulses on ch2 -> hold2=4, update_o once per edge.

Source files
------------

// File: rtl/trigger_scaler_pkg.sv
// Shared constants for the trigger scaler receive path: channel map and default sizing.
package trigger_scaler_pkg;

  localparam int unsigned NUM_TDA_CH        = 4;
  localparam int unsigned NUM_RSVD_CH       = 4;
  localparam int unsigned NUM_CH            = NUM_TDA_CH + NUM_RSVD_CH;

  localparam int unsigned TDA_BASE          = 0;
  localparam int unsigned RSVD_BASE         = TDA_BASE + NUM_TDA_CH;

  localparam int unsigned CNT_WIDTH_DEFAULT = 16;
  localparam int unsigned PERIOD_DEFAULT    = 1000000;

endpackage

// File: rtl/trigger_scaler_chan_cnt.sv
// One scaler channel: saturating pulse counter plus the holding register it
// is snapshotted into at each gate terminal event.
module trigger_scaler_chan_cnt #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 inc_i,
  input  logic                 tc_i,
  output logic [CNT_WIDTH-1:0] hold_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] hold_q, hold_d;
  logic [CNT_WIDTH-1:0] cnt_sat_c;

  // A pulse on the terminal cycle belongs to the closing period.
  always_comb begin
    cnt_sat_c = cnt_q;
    if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_sat_c = cnt_q + CNT_WIDTH'(1);
    end
    cnt_d  = tc_i ? '0 : cnt_sat_c;
    hold_d = tc_i ? cnt_sat_c : hold_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      hold_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end

  assign hold_o = hold_q;

endmodule

// File: rtl/trigger_scaler_counter.sv
// Trigger scaler counter: per-channel pulse counts over a gate period, latched into
// holding registers and read through a req/ack port. Build macro: TRIG_SCALER_PPS_GATE_EN.
module trigger_scaler_counter
  import trigger_scaler_pkg::*;
#(
  parameter int unsigned NCH        = NUM_CH,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEFAULT,
  parameter int unsigned PERIOD     = PERIOD_DEFAULT,
  parameter int unsigned ADDR_WIDTH = $clog2(NCH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  ce_i,
  input  logic [NCH-1:0]        scal_i,
  input  logic                  pps_i,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_ack_o,
  output logic [CNT_WIDTH-1:0]  rd_data_o,
  output logic                  update_o
);

  logic tc_c;

`ifdef TRIG_SCALER_PPS_GATE_EN
  // External gate: rising edge of the registered pps input closes the period.
  logic pps_q, pps_qq;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pps_q  <= 1'b0;
      pps_qq <= 1'b0;
    end else begin
      pps_q  <= pps_i;
      pps_qq <= pps_q;
    end
  end

  assign tc_c = pps_q & ~pps_qq;
`else
  localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [PW-1:0] per_q, per_d;
  logic          pps_unused;

  assign pps_unused = pps_i;
  assign tc_c       = ce_i && (per_q == PW'(PERIOD - 1));

  always_comb begin
    per_d = per_q;
    if (tc_c) begin
      per_d = '0;
    end else if (ce_i) begin
      per_d = per_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      per_q <= '0;
    end else begin
      per_q <= per_d;
    end
  end
`endif

  logic [CNT_WIDTH-1:0] hold [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    trigger_scaler_chan_cnt #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_chan_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .inc_i   (ce_i & scal_i[i]),
      .tc_i    (tc_c),
      .hold_o  (hold[i])
    );
  end

  logic                 rd_ack_q, rd_ack_d;
  logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                 update_q, update_d;

  // Reads sample hold before this edge's snapshot, so a read on tc sees the old value.
  always_comb begin
    rd_ack_d  = rd_req_i;
    rd_data_d = rd_data_q;
    if (rd_req_i) begin
      rd_data_d = hold[rd_addr_i];
    end
    update_d  = tc_c;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      update_q  <= 1'b0;
    end else begin
      rd_ack_q  <= rd_ack_d;
      rd_data_q <= rd_data_d;
      update_q  <= update_d;
    end
  end

  assign rd_ack_o  = rd_ack_q;
  assign rd_data_o = rd_data_q;
  assign update_o  = update_q;

endmodule

// File: tb/tb_trigger_scaler_counter.sv
// Directed bench for trigger_scaler_counter: a 16-bit/PERIOD=10 instance and a
// 4-bit/PERIOD=32 instance share stimulus; the latter covers saturation.
module tb_trigger_scaler_counter;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic [7:0]  scal;
  logic        pps;
  logic        rd_req;
  logic [2:0]  rd_addr;

  logic        ack_a, upd_a;
  logic [15:0] data_a;
  logic        ack_b, upd_b;
  logic [3:0]  data_b;

  int tests;
  int fails;

  trigger_scaler_counter #(
    .NCH(8), .CNT_WIDTH(16), .PERIOD(10), .ADDR_WIDTH(3)
  ) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .scal_i(scal), .pps_i(pps),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr),
    .rd_ack_o(ack_a), .rd_data_o(data_a), .update_o(upd_a)
  );

  trigger_scaler_counter #(
    .NCH(8), .CNT_WIDTH(4), .PERIOD(32), .ADDR_WIDTH(3)
  ) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .scal_i(scal), .pps_i(pps),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr),
    .rd_ack_o(ack_b), .rd_data_o(data_b), .update_o(upd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    ce     = 1'b0;
    scal   = '0;
    pps    = 1'b0;
    rd_req = 1'b0;
    tick();
    rst_n  = 1'b1;
  endtask

  task automatic rd(input int c);
    rd_req  = 1'b1;
    rd_addr = 3'(c);
    tick();
    rd_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    ce     = 1'b0;
    scal   = '0;
    pps    = 1'b0;
    rd_req = 1'b0;
    rd_addr = '0;
    #3;
    tests++;
    if (ack_a !== 1'b0 || data_a !== 16'd0 || upd_a !== 1'b0 ||
        ack_b !== 1'b0 || data_b !== 4'd0 || upd_b !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: ack=%b data=%0h upd=%b (b: %b %0h %b), want all 0",
               ack_a, data_a, upd_a, ack_b, data_b, upd_b);
    end
    tick();
    rst_n = 1'b1;
  endtask

`ifndef TRIG_SCALER_PPS_GATE_EN
  task automatic test_basic();
    int n_upd;
    int upd_k;
    logic [15:0] exp;
    do_reset();
    ce = 1'b1;
    n_upd = 0;
    upd_k = -1;
    for (int k = 0; k < 10; k++) begin
      scal = '0;
      scal[0] = (k < 3);
      scal[5] = (k < 7);
      tick();
      if (upd_a) begin n_upd++; upd_k = k; end
    end
    ce = 1'b0;
    scal = '0;
    tick();
    if (upd_a) n_upd++;
    tests++;
    if (n_upd !== 1 || upd_k !== 9) begin
      fails++;
      $display("FAIL basic_update: got %0d pulses last at k=%0d, want 1 at k=9", n_upd, upd_k);
    end
    for (int c = 0; c < 8; c++) begin
      exp = (c == 0) ? 16'd3 : (c == 5) ? 16'd7 : 16'd0;
      rd(c);
      tests++;
      if (ack_a !== 1'b1 || data_a !== exp) begin
        fails++;
        $display("FAIL basic_read ch%0d: ack=%b data=%0d, want ack=1 data=%0d", c, ack_a, data_a, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d [3];
    logic [2:0]  addrs [3];
    addrs[0] = 3'd0; addrs[1] = 3'd1; addrs[2] = 3'd5;
    exp_d[0] = 16'd3; exp_d[1] = 16'd0; exp_d[2] = 16'd7;
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_addr = addrs[i];
      tick();
      tests++;
      if (ack_a !== 1'b1 || data_a !== exp_d[i]) begin
        fails++;
        $display("FAIL b2b_read %0d: ack=%b data=%0d, want ack=1 data=%0d", i, ack_a, data_a, exp_d[i]);
      end
    end
    rd_req = 1'b0;
    rd_addr = 3'd0;
    tick();
    tests++;
    if (ack_a !== 1'b0 || data_a !== 16'd7) begin
      fails++;
      $display("FAIL b2b_hold: ack=%b data=%0d, want ack=0 data=7", ack_a, data_a);
    end
  endtask

  task automatic test_reset_mid();
    int upd_k;
    rd(5);
    for (int k = 0; k < 5; k++) begin
      ce = 1'b1;
      scal = 8'h01;
      tick();
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (ack_a !== 1'b0 || data_a !== 16'd0 || upd_a !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_outputs: ack=%b data=%0d upd=%b, want 0 0 0", ack_a, data_a, upd_a);
    end
    ce = 1'b0;
    scal = '0;
    tick();
    rst_n = 1'b1;
    ce = 1'b1;
    upd_k = -1;
    for (int k = 0; k < 10; k++) begin
      scal = (k < 2) ? 8'h01 : 8'h00;
      tick();
      if (upd_a && upd_k < 0) upd_k = k;
    end
    ce = 1'b0;
    scal = '0;
    tests++;
    if (upd_k !== 9) begin
      fails++;
      $display("FAIL reset_mid_period: first update at k=%0d, want k=9", upd_k);
    end
    rd(0);
    tests++;
    if (data_a !== 16'd2) begin
      fails++;
      $display("FAIL reset_mid_ch0: data=%0d, want 2", data_a);
    end
    rd(5);
    tests++;
    if (data_a !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid_ch5: data=%0d, want 0", data_a);
    end
  endtask

  task automatic test_saturation();
    int upd_k;
    do_reset();
    ce = 1'b1;
    upd_k = -1;
    for (int k = 0; k < 32; k++) begin
      scal = (k < 20) ? 8'h08 : 8'h00;
      tick();
      if (upd_b && upd_k < 0) upd_k = k;
    end
    ce = 1'b0;
    scal = '0;
    tests++;
    if (upd_k !== 31) begin
      fails++;
      $display("FAIL sat_update: first update at k=%0d, want k=31", upd_k);
    end
    rd(3);
    tests++;
    if (ack_b !== 1'b1 || data_b !== 4'd15) begin
      fails++;
      $display("FAIL sat_hold: ack=%b data=%0d, want ack=1 data=15", ack_b, data_b);
    end
    ce = 1'b1;
    for (int k = 0; k < 32; k++) tick();
    ce = 1'b0;
    rd(3);
    tests++;
    if (data_b !== 4'd0) begin
      fails++;
      $display("FAIL sat_empty_period: data=%0d, want 0", data_b);
    end
  endtask

  task automatic test_tc_pulse();
    do_reset();
    ce = 1'b1;
    for (int k = 0; k < 10; k++) begin
      scal = (k < 2 || k == 9) ? 8'h02 : 8'h00;
      tick();
    end
    ce = 1'b0;
    scal = '0;
    rd(1);
    tests++;
    if (data_a !== 16'd3) begin
      fails++;
      $display("FAIL tc_pulse_closing: data=%0d, want 3", data_a);
    end
    ce = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    ce = 1'b0;
    rd(1);
    tests++;
    if (data_a !== 16'd0) begin
      fails++;
      $display("FAIL tc_pulse_next: data=%0d, want 0", data_a);
    end
  endtask

  task automatic test_read_on_tc();
    do_reset();
    ce = 1'b1;
    for (int k = 0; k < 10; k++) begin
      scal = (k < 4) ? 8'h04 : 8'h00;
      tick();
    end
    for (int k = 0; k < 9; k++) begin
      scal = (k < 6) ? 8'h04 : 8'h00;
      tick();
    end
    scal = '0;
    rd_req = 1'b1;
    rd_addr = 3'd2;
    tick();
    tests++;
    if (upd_a !== 1'b1 || ack_a !== 1'b1 || data_a !== 16'd4) begin
      fails++;
      $display("FAIL read_on_tc: upd=%b ack=%b data=%0d, want 1 1 4", upd_a, ack_a, data_a);
    end
    ce = 1'b0;
    tick();
    rd_req = 1'b0;
    tests++;
    if (ack_a !== 1'b1 || data_a !== 16'd6) begin
      fails++;
      $display("FAIL read_after_tc: ack=%b data=%0d, want 1 6", ack_a, data_a);
    end
  endtask

  task automatic test_ce_gate();
    int n_upd;
    int upd_k;
    do_reset();
    n_upd = 0;
    upd_k = -1;
    for (int k = 0; k < 20; k++) begin
      ce = (k % 2 == 0);
      scal = 8'h10;
      tick();
      if (upd_a) begin n_upd++; upd_k = k; end
    end
    ce = 1'b0;
    scal = '0;
    tests++;
    if (n_upd !== 1 || upd_k !== 18) begin
      fails++;
      $display("FAIL ce_gate_update: %0d pulses last at k=%0d, want 1 at k=18", n_upd, upd_k);
    end
    rd(4);
    tests++;
    if (data_a !== 16'd10) begin
      fails++;
      $display("FAIL ce_gate_count: data=%0d, want 10", data_a);
    end
  endtask
`else
  task automatic test_pps_gate();
    int n_upd;
    do_reset();
    ce = 1'b1;
    n_upd = 0;
    for (int k = 0; k < 50; k++) begin
      scal = (k < 4) ? 8'h04 : 8'h00;
      pps  = (k >= 10 && k < 15);
      tick();
      if (upd_a) n_upd++;
    end
    tests++;
    if (n_upd !== 1) begin
      fails++;
      $display("FAIL pps_update_1: %0d pulses, want 1", n_upd);
    end
    rd(2);
    tests++;
    if (data_a !== 16'd4) begin
      fails++;
      $display("FAIL pps_hold2: data=%0d, want 4", data_a);
    end
    n_upd = 0;
    scal = '0;
    for (int k = 0; k < 50; k++) begin
      pps = (k >= 10 && k < 15);
      tick();
      if (upd_a) n_upd++;
    end
    tests++;
    if (n_upd !== 1) begin
      fails++;
      $display("FAIL pps_update_2: %0d pulses, want 1", n_upd);
    end
    rd(2);
    tests++;
    if (data_a !== 16'd0) begin
      fails++;
      $display("FAIL pps_hold2_empty: data=%0d, want 0", data_a);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
`ifndef TRIG_SCALER_PPS_GATE_EN
    test_basic();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    test_tc_pulse();
    test_read_on_tc();
    test_ce_gate();
`else
    test_pps_gate();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
